sort_queue: RTL and testbench

Parametrised systolic priority queue with key+tag payload and independent push/pop handshakes; the successor to the push-or-pop sort chain. DEPTH entries are held fully sorted at all times, so the best key (smallest for "UP", largest for "DOWN") is always presented registered at the head. It adds occupancy tracking, full/empty flags, reject signalling, same-cycle push+pop replacement, flush, and stable ordering of equal keys. It sits between a key producer (scheduler, timestamp merger) and a consumer draining in priority order.

---
 rtl/sort_queue.sv | 187 ++++++++++++++++++
 tb/tb_sort_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_queue.sv
// sort_queue: systolic priority queue holding DEPTH {key, tag} entries fully
// sorted at all times. The best entry (smallest key for "UP", largest for
// "DOWN") sits in node 0 and drives the head outputs straight from registers.
// Push, pop and push+pop (replace) are each accepted at one per cycle; equal
// keys leave in arrival order.
module sort_queue #(
  parameter int unsigned KEY_WIDTH = 16,
  parameter int unsigned TAG_WIDTH = 8,
  parameter int unsigned DEPTH     = 16,
  parameter string       DIR       = "UP"
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clk_en_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [KEY_WIDTH-1:0]         push_key_i,
  input  logic [TAG_WIDTH-1:0]         push_tag_i,
  input  logic                         pop_i,
  output logic                         head_valid_o,
  output logic [KEY_WIDTH-1:0]         head_key_o,
  output logic [TAG_WIDTH-1:0]         head_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         drop_o
);

  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);
  localparam bit          ASCEND    = (DIR == "UP");
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

  // Node storage and next state.
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [KEY_WIDTH-1:0] key_q [DEPTH];
  logic [KEY_WIDTH-1:0] key_d [DEPTH];
  logic [TAG_WIDTH-1:0] tag_q [DEPTH];
  logic [TAG_WIDTH-1:0] tag_d [DEPTH];

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 drop_q, drop_d;

  // Post-pop view of the nodes, and per-node "new key wins here" flags.
  logic [DEPTH-1:0]     s_valid;
  logic [KEY_WIDTH-1:0] s_key [DEPTH];
  logic [TAG_WIDTH-1:0] s_tag [DEPTH];
  logic [DEPTH-1:0]     beat;

  logic active;
  logic is_empty;
  logic is_full;
  logic pop_eff;
  logic push_eff;

  // Strict comparison keeps a new key behind existing equal keys (FIFO ties).
  function automatic logic is_better(input logic [KEY_WIDTH-1:0] a,
                                     input logic [KEY_WIDTH-1:0] b);
    if (ASCEND) return a < b;
    else        return a > b;
  endfunction

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);

  // Decode which operations actually take effect this cycle.
  always_comb begin
    // NOTE: every signal driven in always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    active   = clk_en_i & ~flush_i;
    pop_eff  = active & pop_i & ~is_empty;
    push_eff = active & push_i & (~is_full | pop_eff);
    drop_d   = active & push_i & ~push_eff;
  end

  // Shifted view: with a pop every node sees its upper neighbour, the top
  // node sees an invalid entry; without a pop the view is the nodes as held.
  always_comb begin
    s_valid = valid_q;
    s_key   = key_q;
    s_tag   = tag_q;
    if (pop_eff) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        s_valid[i] = valid_q[i+1];
        s_key[i]   = key_q[i+1];
        s_tag[i]   = tag_q[i+1];
      end
      s_valid[DEPTH-1] = 1'b0;
      s_key[DEPTH-1]   = '0;
      s_tag[DEPTH-1]   = '0;
    end
  end

  // Broadcast compare: the flags form a 0..0 1..1 pattern because the view is
  // sorted and invalid nodes always lose; the first 1 is the insertion index.
  always_comb begin
    beat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      beat[i] = ~s_valid[i] | is_better(push_key_i, s_key[i]);
    end
  end

  // Next node contents: hold below the insertion index, take the new entry at
  // it, take the lower neighbour above it.
  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    tag_d   = tag_q;
    if (flush_i) begin
      valid_d = '0;
    end else begin
      valid_d = s_valid;
      key_d   = s_key;
      tag_d   = s_tag;
      if (push_eff) begin
        if (beat[0]) begin
          valid_d[0] = 1'b1;
          key_d[0]   = push_key_i;
          tag_d[0]   = push_tag_i;
        end
        for (int i = 1; i < DEPTH; i++) begin
          if (beat[i]) begin
            if (!beat[i-1]) begin
              valid_d[i] = 1'b1;
              key_d[i]   = push_key_i;
              tag_d[i]   = push_tag_i;
            end else begin
              valid_d[i] = s_valid[i-1];
              key_d[i]   = s_key[i-1];
              tag_d[i]   = s_tag[i-1];
            end
          end
        end
      end
    end
  end

  // Occupancy: a replace leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push_eff && !pop_eff) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (pop_eff && !push_eff) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  // Node and occupancy registers, frozen while the global enable is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the nodes are flops, not a RAM, so clearing keys and tags on
      // reset is cheap and makes the head outputs deterministic out of reset.
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (clk_en_i) begin
      // NOTE: state registers use non-blocking assignments so every node
      // samples its neighbours' old values, which the shift relies on.
      valid_q <= valid_d;
      count_q <= count_d;
      key_q   <= key_d;
      tag_q   <= tag_d;
    end
  end

  // Reject pulse lives exactly one cycle, independent of the enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign head_valid_o = valid_q[0];
  assign head_key_o   = key_q[0];
  assign head_tag_o   = tag_q[0];
  assign count_o      = count_q;
  assign empty_o      = is_empty;
  assign full_o       = is_full;
  assign drop_o       = drop_q;

endmodule

// File: tb/tb_sort_queue.sv
// Bench for sort_queue: two DEPTH-4 instances ("UP" and "DOWN") share one
// stimulus stream; each is compared every cycle against an ordered-list model.
module tb_sort_queue;

  localparam int KW    = 16;
  localparam int TW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [KW-1:0] key;
    logic [TW-1:0] tag;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en, flush, push, pop;
  logic [KW-1:0] push_key;
  logic [TW-1:0] push_tag;

  logic          up_hv, dn_hv, up_emp, dn_emp, up_ful, dn_ful, up_drp, dn_drp;
  logic [KW-1:0] up_hk, dn_hk;
  logic [TW-1:0] up_ht, dn_ht;
  logic [CW-1:0] up_cnt, dn_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ent_t q_up[$];
  ent_t q_dn[$];
  bit   drop_exp [2];

  always #5 clk = ~clk;

  sort_queue #(.KEY_WIDTH(KW), .TAG_WIDTH(TW), .DEPTH(DEPTH), .DIR("UP")) u_up (
    .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en), .flush_i(flush),
    .push_i(push), .push_key_i(push_key), .push_tag_i(push_tag), .pop_i(pop),
    .head_valid_o(up_hv), .head_key_o(up_hk), .head_tag_o(up_ht),
    .count_o(up_cnt), .empty_o(up_emp), .full_o(up_ful), .drop_o(up_drp)
  );

  sort_queue #(.KEY_WIDTH(KW), .TAG_WIDTH(TW), .DEPTH(DEPTH), .DIR("DOWN")) u_dn (
    .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en), .flush_i(flush),
    .push_i(push), .push_key_i(push_key), .push_tag_i(push_tag), .pop_i(pop),
    .head_valid_o(dn_hv), .head_key_o(dn_hk), .head_tag_o(dn_ht),
    .count_o(dn_cnt), .empty_o(dn_emp), .full_o(dn_ful), .drop_o(dn_drp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: ordered list; pop takes the front, push goes before the first
  // entry it strictly beats, otherwise to the back.
  task automatic model_update(input int d, input bit en, input bit fl, input bit pu,
                              input bit po, input logic [KW-1:0] k, input logic [TW-1:0] t);
    ent_t q[$];
    ent_t e;
    bit   pe, qe;
    int   pos;
    if (d == 0) q = q_up; else q = q_dn;
    drop_exp[d] = 1'b0;
    if (en) begin
      if (fl) begin
        q.delete();
      end else begin
        pe = po && (q.size() > 0);
        qe = pu && ((q.size() < DEPTH) || pe);
        drop_exp[d] = pu && !qe;
        if (pe) e = q.pop_front();
        if (qe) begin
          pos = q.size();
          for (int i = 0; i < q.size(); i++) begin
            if ((d == 0) ? (k < q[i].key) : (k > q[i].key)) begin
              pos = i;
              break;
            end
          end
          e.key = k;
          e.tag = t;
          q.insert(pos, e);
        end
      end
    end
    if (d == 0) q_up = q; else q_dn = q;
  endtask

  task automatic compare(input int d);
    ent_t          q[$];
    string         nm;
    logic          hv, emp, ful, drp;
    logic [KW-1:0] hk;
    logic [TW-1:0] ht;
    logic [CW-1:0] cnt;
    if (d == 0) begin
      q = q_up; nm = "up";
      hv = up_hv; hk = up_hk; ht = up_ht; cnt = up_cnt; emp = up_emp; ful = up_ful; drp = up_drp;
    end else begin
      q = q_dn; nm = "dn";
      hv = dn_hv; hk = dn_hk; ht = dn_ht; cnt = dn_cnt; emp = dn_emp; ful = dn_ful; drp = dn_drp;
    end
    check({nm, " count"}, 32'(cnt), 32'(q.size()));
    check({nm, " head_valid"}, 32'(hv), 32'(q.size() > 0));
    check({nm, " empty"}, 32'(emp), 32'(q.size() == 0));
    check({nm, " full"}, 32'(ful), 32'(q.size() == DEPTH));
    check({nm, " drop"}, 32'(drp), 32'(drop_exp[d]));
    if (q.size() > 0) begin
      check({nm, " head_key"}, 32'(hk), 32'(q[0].key));
      check({nm, " head_tag"}, 32'(ht), 32'(q[0].tag));
    end
  endtask

  task automatic step(input bit en, input bit fl, input bit pu, input bit po,
                      input logic [KW-1:0] k, input logic [TW-1:0] t);
    clk_en = en; flush = fl; push = pu; pop = po; push_key = k; push_tag = t;
    @(posedge clk);
    #1;
    model_update(0, en, fl, pu, po, k, t);
    model_update(1, en, fl, pu, po, k, t);
    compare(0);
    compare(1);
  endtask

  task automatic do_push(input logic [KW-1:0] k, input logic [TW-1:0] t);
    step(1'b1, 1'b0, 1'b1, 1'b0, k, t);
  endtask

  task automatic do_pop();
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  task automatic do_flush();
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_cleared(input string when);
    check({when, " up head_valid"}, 32'(up_hv), 0);
    check({when, " up head_key"}, 32'(up_hk), 0);
    check({when, " up head_tag"}, 32'(up_ht), 0);
    check({when, " up count"}, 32'(up_cnt), 0);
    check({when, " up empty"}, 32'(up_emp), 1);
    check({when, " up full"}, 32'(up_ful), 0);
    check({when, " up drop"}, 32'(up_drp), 0);
    check({when, " dn head_valid"}, 32'(dn_hv), 0);
    check({when, " dn count"}, 32'(dn_cnt), 0);
    check({when, " dn head_key"}, 32'(dn_hk), 0);
  endtask

  initial begin
    logic [TW-1:0] tags_up [4];
    logic [TW-1:0] tags_dn [4];
    logic [KW-1:0] heads   [4];
    logic [TW-1:0] tag_ctr;
    logic [KW-1:0] k;
    bit            en, fl, pu, po;

    rst_n = 1'b0; clk_en = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
    push_key = '0; push_tag = '0;
    #2;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Ordering: 7,3,9,1 fill the queue; pops come out 1,3,7,9.
    do_push(16'd7, 8'h07);
    do_push(16'd3, 8'h03);
    do_push(16'd9, 8'h09);
    do_push(16'd1, 8'h01);
    check("fill count", 32'(up_cnt), 4);
    check("fill full", 32'(up_ful), 1);
    // Overflow: rejected push, then replace (pop 1, insert 5).
    do_push(16'd5, 8'h05);
    check("overflow drop", 32'(up_drp), 1);
    check("overflow head", 32'(up_hk), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    check("drop one cycle", 32'(up_drp), 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'd5, 8'h05);
    check("replace count", 32'(up_cnt), 4);
    heads[0] = 16'd3; heads[1] = 16'd5; heads[2] = 16'd7; heads[3] = 16'd9;
    for (int i = 0; i < 4; i++) begin
      check("replace order", 32'(up_hk), 32'(heads[i]));
      do_pop();
    end
    check("drained empty", 32'(up_emp), 1);
    check("drained head_valid", 32'(up_hv), 0);

    // Stability: equal keys leave in arrival order in both directions.
    do_push(16'd4, 8'hA);
    do_push(16'd4, 8'hB);
    do_push(16'd2, 8'hC);
    do_push(16'd4, 8'hD);
    tags_up[0] = 8'hC; tags_up[1] = 8'hA; tags_up[2] = 8'hB; tags_up[3] = 8'hD;
    tags_dn[0] = 8'hA; tags_dn[1] = 8'hB; tags_dn[2] = 8'hD; tags_dn[3] = 8'hC;
    for (int i = 0; i < 4; i++) begin
      check("stable up tag", 32'(up_ht), 32'(tags_up[i]));
      check("stable dn tag", 32'(dn_ht), 32'(tags_dn[i]));
      do_pop();
    end

    // Replace with a better key.
    do_push(16'd5, 8'h50);
    do_push(16'd6, 8'h60);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 8'h20);
    check("better head", 32'(up_hk), 2);
    check("better count", 32'(up_cnt), 2);
    do_pop();
    check("better next", 32'(up_hk), 6);
    do_flush();

    // Empty edge cases.
    do_pop();
    check("pop empty drop", 32'(up_drp), 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'd8, 8'h08);
    check("push+pop empty count", 32'(up_cnt), 1);
    check("push+pop empty head", 32'(up_hk), 8);

    // Enable low freezes everything; flush beats a concurrent push.
    do_push(16'd12, 8'h12);
    do_push(16'd10, 8'h10);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 8'hEE);
    check("disabled count", 32'(up_cnt), 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 8'h11);
    check("flush count", 32'(up_cnt), 0);
    check("flush drop", 32'(up_drp), 0);

    // Randomised traffic with small key range to force ties.
    tag_ctr = '0;
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 79) == 0);
      pu = $urandom_range(0, 1);
      po = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0:       k = '0;
        1:       k = '1;
        default: k = KW'($urandom_range(0, 7));
      endcase
      tag_ctr++;
      step(en, fl, pu, po, k, tag_ctr);
    end

    // Asynchronous reset between edges clears outputs at once.
    for (int i = 0; i < 3; i++) do_push(KW'(20 + i), TW'(i));
    #2;
    rst_n = 1'b0;
    #1;
    q_up.delete();
    q_dn.delete();
    drop_exp[0] = 1'b0;
    drop_exp[1] = 1'b0;
    check_cleared("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_push(16'd33, 8'h33);
    check("post reset head", 32'(up_hk), 33);
    check("post reset count", 32'(up_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
